// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes,
// FSM states, MMIO register offsets and byte-lane helpers.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] MMIO_LED = 4'h0;
  localparam logic [3:0] MMIO_CYC = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  function automatic logic [3:0] lane_be(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    unique case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(
    input logic [1:0]  sz,
    input logic [31:0] wd
  );
    unique case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [2:0]  f3,
    input logic [1:0]  a,
    input logic [31:0] w
  );
    logic [31:0] s;
    s = w >> {a, 3'b000};
    unique case (f3)
      F3_LB:   return {{24{s[7]}}, s[7:0]};
      F3_LH:   return {{16{s[15]}}, s[15:0]};
      F3_LBU:  return {24'b0, s[7:0]};
      F3_LHU:  return {16'b0, s[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Four byte-lane synchronous RAMs with per-lane write enable.
// Read data is registered and holds while en is low.
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[i]) mem[addr] <= wdata[8*i +: 8];
        rd_q <= mem[addr];
      end
    end

    assign rdata[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time into byte-lane RAM
// or a small LED/cycle-counter MMIO window, with error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_END =
    {1'b0, DMEM_BASE} + 33'(4 * DEPTH_WORDS);

  state_e state_q, state_d;

  logic        wren_q, wren_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] mrd_q, mrd_d;

  logic        f3_ok, misal;
  logic        hit_ram, hit_mmio, acc_err;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram_rd;

  always_comb begin
    if (wren_q) begin
      f3_ok = f3_q inside {F3_SB, F3_SH, F3_SW};
    end else begin
      f3_ok = f3_q inside
        {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    end
    misal = (f3_q[1:0] == 2'b01 && addr_q[0])
         || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    hit_ram = {1'b0, addr_q} >= {1'b0, DMEM_BASE}
           && {1'b0, addr_q} < RAM_END;
    hit_mmio = addr_q[31:4] == MMIO_BASE[31:4];
    acc_err = !f3_ok || misal || !(hit_ram || hit_mmio);
    be = lane_be(f3_q[1:0], addr_q[1:0]);
    wlane = lane_wdata(f3_q[1:0], wdata_q);
    ram_idx = AW'((addr_q - DMEM_BASE) >> 2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req_valid) state_d = ST_ACCESS;
      ST_ACCESS:  state_d = ST_RESPOND;
      ST_RESPOND: if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = state_q == ST_IDLE;
    rsp_valid = state_q == ST_RESPOND;
    ram_en    = state_q == ST_ACCESS && hit_ram && !acc_err;
    ram_we    = wren_q ? be : 4'b0000;
    rsp_error = rsp_valid && acc_err;
    rsp_rdata = '0;
    if (rsp_valid && !acc_err && !wren_q) begin
      rsp_rdata = load_ext(f3_q, addr_q[1:0],
                           hit_ram ? ram_rd : mrd_q);
    end
  end

  always_comb begin
    wren_d  = wren_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    led_d   = led_q;
    mrd_d   = mrd_q;
    cnt_d   = cnt_q + 32'd1;
    if (state_q == ST_IDLE && req_valid) begin
      wren_d  = req_wren;
      f3_d    = req_funct3;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    if (state_q == ST_ACCESS) begin
      // Snapshot the MMIO word now so the response holds still.
      unique case (addr_q[3:2])
        MMIO_LED[3:2]: mrd_d = {28'b0, led_q};
        MMIO_CYC[3:2]: mrd_d = cnt_q;
        default:       mrd_d = '0;
      endcase
      if (wren_q && hit_mmio && !acc_err
          && addr_q[3:2] == MMIO_LED[3:2] && be[0]) begin
        led_d = wlane[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wren_q  <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      mrd_q   <= '0;
    end else begin
      wren_q  <= wren_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      mrd_q   <= mrd_d;
    end
  end

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW(AW)
  ) u_bram (
    .clk(clk),
    .en(ram_en),
    .we(ram_we),
    .addr(ram_idx),
    .wdata(wlane),
    .rdata(ram_rd)
  );

  assign {blue, green, red, led} = led_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 512, data RAM size in 32-bit words (power of two).
REQ-002 Parameter DMEM_BASE, default 32'h0000_2000, byte address of RAM word 0.
REQ-003 Parameter MMIO_BASE, default 32'hFFFF_FFF0, base of the 16-byte peripheral window.
REQ-004 Port: clk  in  1  sole clock, all state updates on posedge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: req_valid in 1, req_ready out 1; request handshake, transfer when both are high at posedge.
REQ-007 Ports: req_wren in 1 (1 = store), req_funct3 in 3 (RV32I load/store funct3), req_addr in 32 (byte address), req_wdata in 32 (store data, LSB-aligned).
REQ-008 Ports: rsp_valid out 1, rsp_ready in 1; response handshake, transfer when both are high at posedge.
REQ-009 Ports: rsp_rdata out 32 (extended load data, 0 for stores and errors), rsp_error out 1 (access fault).
REQ-010 Ports: led, red, green, blue  out  1 each  peripheral output bits, active-high.

Function
REQ-011 FSM states are IDLE, ACCESS and RESPOND; req_ready SHALL be high only in IDLE.
REQ-012 IDLE: on handshake, latch wren/funct3/addr/wdata and go to ACCESS.
REQ-013 ACCESS: perform the RAM write or the synchronous RAM read, then go to RESPOND.
REQ-014 RESPOND: rsp_valid high, outputs stable, until rsp_ready is high at posedge, then go to IDLE.
REQ-015 Minimum latency: rsp_valid first high 2 cycles after request handshake; next request can be accepted the cycle after the response handshake.
REQ-016 Valid load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; valid store funct3: 000 sb, 001 sh, 010 sw; any other value sets error.
REQ-017 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=00; a misaligned access sets error.
REQ-018 Address decode: RAM when DMEM_BASE <= addr < DMEM_BASE + 4*DEPTH_WORDS; MMIO when addr[31:4] == MMIO_BASE[31:4]; anything else sets error.
REQ-019 Byte order is little-endian; byte enables come from addr[1:0] and size; sb/sh replicate wdata low byte/half into the selected lanes.
REQ-020 Loads: lb/lh sign-extend and lbu/lhu zero-extend the selected lane(s) to 32 bits.
REQ-021 Error access: no RAM or MMIO state changes, rsp_rdata = 0, rsp_error = 1, response timing unchanged.
REQ-022 MMIO +0x0: R/W, bits[3:0] = {blue, green, red, led}, upper bits read 0.
REQ-023 MMIO +0x4: read-only free-running 32-bit cycle counter, wraps 0xFFFF_FFFF to 0; writes to it are ignored without error.
REQ-024 MMIO +0x8 and +0xC read 0; writes are ignored without error.
REQ-025 MMIO accepts any valid size and applies the same lane rules as RAM.
REQ-026 req_* is ignored outside IDLE; back-to-back accepted requests are served strictly in order.

Reset
REQ-027 On reset assertion, immediately: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, LED register = 0, cycle counter = 0.
REQ-028 Reset mid-transaction aborts it with no response; a store still in ACCESS may be lost.
REQ-029 RAM contents are not reset.

Structure
REQ-030 Shared package dmem_pkg holds the funct3 load/store constants, the FSM state enum, and the MMIO offsets.
REQ-031 One sub-module, dmem_bram: 4 byte-lane synchronous RAMs of DEPTH_WORDS x 8 with per-lane write enables and registered read.

Verification
REQ-032 sw 0xDEADBEEF @0x2000, then lw @0x2000 -> rdata 0xDEADBEEF, error 0; lb @0x2003 -> 0xFFFFFFDE; lbu @0x2003 -> 0x000000DE.
REQ-033 sh 0x1234 @0x2002 onto 0xDEADBEEF -> lw gives 0x1234BEEF; lh @0x2001 -> error 1, rdata 0, RAM unchanged.
REQ-034 sw 0x5 @0xFFFFFFF0 -> led = 1, green = 1, red = 0, blue = 0; lw @0xFFFFFFF0 -> 0x00000005.
REQ-035 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rdata stable, req_ready = 0 throughout; the response completes on the cycle rsp_ready rises.
REQ-036 lw @0x0000_0100 (unmapped) and funct3 = 011 -> each gives error 1; a following valid lw succeeds.
REQ-037 Assert reset during ACCESS -> next cycle shows rsp_valid = 0, req_ready = 1, LEDs off; two reads of the cycle counter N cycles apart differ by N.
